// File: rtl/sap_control.sv
// sap_control: microcoded control sequencer for the 8-bit SAP-style datapath.
// Produces the per-cycle control word, the T0..T4 microstep counter,
// the carry/zero flag register and the halt latch.
// Optional build macro: SAP_EARLY_NEXT_EN. When it is defined, the sequencer
// returns to T0 as soon as the rest of the instruction has no work left.
module sap_control #(
    parameter int unsigned N     = 4,
    parameter int unsigned STEPS = 5
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          go,
    input  logic [N-1:0]  ir,
    input  logic          alu_carry,
    input  logic          alu_zero,
    output logic [15:0]   ctrl,
    output logic [2:0]    step,
    output logic          flag_c,
    output logic          flag_z,
    output logic          halted
);

    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam step_t LAST = step_t'(3'(STEPS - 1));

    // Control words
    localparam logic [CW-1:0] W_FETCH0 = 16'h4004;  // CO|MI
    localparam logic [CW-1:0] W_FETCH1 = 16'h1408;  // RO|II|CE
    localparam logic [CW-1:0] W_IO_MI  = 16'h4800;
    localparam logic [CW-1:0] W_RO_AI  = 16'h1200;
    localparam logic [CW-1:0] W_RO_BI  = 16'h1020;
    localparam logic [CW-1:0] W_ADD    = 16'h0281;  // SO|AI|FI
    localparam logic [CW-1:0] W_SUB    = 16'h02C1;  // SO|SU|AI|FI
    localparam logic [CW-1:0] W_AO_RI  = 16'h2100;
    localparam logic [CW-1:0] W_IO_AI  = 16'h0A00;
    localparam logic [CW-1:0] W_JUMP   = 16'h0802;  // IO|J
    localparam logic [CW-1:0] W_OUT    = 16'h0110;  // AO|OI
    localparam logic [CW-1:0] W_HLT    = 16'h8000;

    // Only a 4-bit opcode field is supported
    if (N != 4) begin : g_bad_n
        $error("sap_control: N must be 4");
    end

    step_t step_q;
    step_t step_succ;
    step_t step_nxt;

    // Microcode ROM: control word for a given step, opcode and flag state
    function automatic logic [CW-1:0] decode(input logic [2:0] s, input logic [3:0] op,
                                             input logic fc, input logic fz);
        logic [CW-1:0] w;
        w = '0;
        case (s)
            3'd0: w = W_FETCH0;
            3'd1: w = W_FETCH1;
            default: begin
                case (op)
                    4'h1: case (s)
                              3'd2:    w = W_IO_MI;
                              3'd3:    w = W_RO_AI;
                              default: w = '0;
                          endcase
                    4'h2, 4'h3: case (s)
                              3'd2:    w = W_IO_MI;
                              3'd3:    w = W_RO_BI;
                              3'd4:    w = (op == 4'h3) ? W_SUB : W_ADD;
                              default: w = '0;
                          endcase
                    4'h4: case (s)
                              3'd2:    w = W_IO_MI;
                              3'd3:    w = W_AO_RI;
                              default: w = '0;
                          endcase
                    4'h5: w = (s == 3'd2) ? W_IO_AI : '0;
                    4'h6: w = (s == 3'd2) ? W_JUMP : '0;
                    4'h7: w = (s == 3'd2 && fc) ? W_JUMP : '0;
                    4'h8: w = (s == 3'd2 && fz) ? W_JUMP : '0;
                    4'hE: w = (s == 3'd2) ? W_OUT : '0;
                    4'hF: w = (s == 3'd2) ? W_HLT : '0;
                    default: w = '0;
                endcase
            end
        endcase
        return w;
    endfunction

    // Control word: halt dominates, go=0 freezes all loads
    always_comb begin
        ctrl = '0;
        if (halted) begin
            ctrl = W_HLT;
        end else if (go) begin
            ctrl = decode(step_q, ir[3:0], flag_c, flag_z);
        end
    end

    // Next microstep, with optional early return to T0
    always_comb begin
        step_succ = step_t'(3'(step_q + 3'd1));
        step_nxt  = (step_q == LAST) ? T0 : step_succ;
`ifdef SAP_EARLY_NEXT_EN
        if (step_q != T0 && decode(step_succ, ir[3:0], flag_c, flag_z) == '0) begin
            step_nxt = T0;
        end
`else
`endif
    end

    // Sequencer state: step counter, flags, halt latch
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            step_q <= T0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            halted <= 1'b0;
        end else begin
            if (ctrl[15]) begin
                halted <= 1'b1;
            end
            if (ctrl[0]) begin
                flag_c <= alu_carry;
                flag_z <= alu_zero;
            end
            // Step freezes on the HLT edge and while halted or stalled
            if (go && !ctrl[15]) begin
                step_q <= step_nxt;
            end
        end
    end

    assign step = step_q;

endmodule
